loop_uart_tx: RTL and testbench

- Downstream consumer of the cyclic playback buffer.
- Pulls one byte at a time from the buffer's combinational read port and serialises it as an 8N1 UART frame on a single TX line, LSB first.
- Runs continuously while enabled and the buffer holds data, so stored content is replayed on the wire indefinitely.
- Sits between the buffer and the board's UART TX pin.

---
 rtl/loop_uart_tx_if.sv | 10 +
 rtl/loop_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_loop_uart_tx.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/loop_uart_tx_if.sv
// Read port of the cyclic playback buffer as seen by loop_uart_tx.
// master = buffer side, slave = UART consumer side.
interface loop_uart_tx_if;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_en;

  modport master (output rd_data, output rd_valid, input rd_en);
  modport slave  (input rd_data, input rd_valid, output rd_en);
endinterface

// File: rtl/loop_uart_tx.sv
// Replays buffer contents as back-to-back 8N1 UART frames, LSB first.
// Define LOOP_UART_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module loop_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int GAP_CYCLES   = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  loop_uart_tx_if.slave  rd,
  output logic           tx,
  output logic           busy,
  output logic           byte_done,
  output logic [15:0]    bytes_sent
);

`ifdef LOOP_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
`endif

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t        r_state, w_state_n;
  logic [BW-1:0] r_baud, w_baud_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_tx, w_tx_n;
  logic [GW-1:0] r_gap, w_gap_n;
  logic [15:0]   r_cnt;
  logic          w_rd_en;
  logic          w_byte_done;
  logic          w_bit_end;
`ifdef LOOP_UART_TX_PARITY_EN
  logic          r_par, w_par_n;
`endif

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_gap   <= '0;
      r_cnt   <= '0;
`ifdef LOOP_UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
      r_gap   <= w_gap_n;
      if (w_byte_done) r_cnt <= r_cnt + 16'd1;
`ifdef LOOP_UART_TX_PARITY_EN
      r_par   <= w_par_n;
`endif
    end
  end

  // tx is registered, so each branch loads the level of the bit that starts next cycle
  always_comb begin
    w_state_n   = r_state;
    w_baud_n    = r_baud;
    w_bit_n     = r_bit;
    w_shift_n   = r_shift;
    w_tx_n      = r_tx;
    w_gap_n     = r_gap;
    w_rd_en     = 1'b0;
    w_byte_done = 1'b0;
`ifdef LOOP_UART_TX_PARITY_EN
    w_par_n     = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_tx_n   = 1'b1;
        w_baud_n = '0;
        w_bit_n  = '0;
        w_gap_n  = '0;
        if (enable && rd.rd_valid) begin
          w_rd_en   = 1'b1;
          w_shift_n = rd.rd_data;
          w_tx_n    = 1'b0;
          w_state_n = START;
`ifdef LOOP_UART_TX_PARITY_EN
          w_par_n   = ^rd.rd_data;
`endif
        end
      end
      START: begin
        if (w_bit_end) begin
          w_baud_n  = '0;
          w_tx_n    = r_shift[0];
          w_state_n = DATA;
        end else begin
          w_baud_n = r_baud + BW'(1);
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_n  = '0;
          w_shift_n = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
`ifdef LOOP_UART_TX_PARITY_EN
            w_tx_n    = r_par;
            w_state_n = PARITY;
`else
            w_tx_n    = 1'b1;
            w_state_n = STOP;
`endif
          end else begin
            w_bit_n = r_bit + 3'd1;
            w_tx_n  = r_shift[1];
          end
        end else begin
          w_baud_n = r_baud + BW'(1);
        end
      end
`ifdef LOOP_UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_baud_n  = '0;
          w_tx_n    = 1'b1;
          w_state_n = STOP;
        end else begin
          w_baud_n = r_baud + BW'(1);
        end
      end
`endif
      STOP: begin
        w_tx_n = 1'b1;
        if (w_bit_end) begin
          w_baud_n    = '0;
          w_byte_done = 1'b1;
          w_state_n   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          w_baud_n = r_baud + BW'(1);
        end
      end
      GAP: begin
        w_tx_n = 1'b1;
        if (r_gap == GAP_LAST) begin
          w_gap_n   = '0;
          w_state_n = IDLE;
        end else begin
          w_gap_n = r_gap + GW'(1);
        end
      end
      default: begin
        w_tx_n    = 1'b1;
        w_state_n = IDLE;
      end
    endcase
  end

  assign rd.rd_en   = w_rd_en;
  assign tx         = r_tx;
  assign busy       = (r_state != IDLE);
  assign byte_done  = w_byte_done;
  assign bytes_sent = r_cnt;

endmodule

// File: tb/tb_loop_uart_tx.sv
// Randomized self-checking bench for loop_uart_tx against a cycle-level frame model.
// Honours LOOP_UART_TX_PARITY_EN for the expected frame shape.
module tb_loop_uart_tx;
  localparam int C = 4;
  localparam int G = 3;
`ifdef LOOP_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int PERIOD = NB * C + G + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        tx, busy, byte_done;
  logic [15:0] bytes_sent;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;

  loop_uart_tx_if bus ();

  loop_uart_tx #(.CLKS_PER_BIT(C), .GAP_CYCLES(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .rd         (bus),
    .tx         (tx),
    .busy       (busy),
    .byte_done  (byte_done),
    .bytes_sent (bytes_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Model: the expected tx level for every upcoming cycle of the frame in flight
  logic q_tx[$];
  bit   q_last[$];
  int   gap_left = 0;
  int   m_cnt = 0;

  function automatic void push_frame(input logic [7:0] d);
    logic b;
    for (int k = 0; k < NB; k++) begin
      if (k == 0) b = 1'b0;
      else if (k <= 8) b = d[k-1];
`ifdef LOOP_UART_TX_PARITY_EN
      else if (k == 9) b = ^d;
`endif
      else b = 1'b1;
      for (int c = 0; c < C; c++) begin
        q_tx.push_back(b);
        q_last.push_back((k == NB - 1) && (c == C - 1));
      end
    end
  endfunction

  always @(negedge clk) begin
    bit idle, last;
    logic et;
    if (!rst_n) begin
      q_tx.delete();
      q_last.delete();
      gap_left = 0;
      m_cnt = 0;
      check("rst_tx", {31'b0, tx}, 1);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_rd_en", {31'b0, bus.rd_en}, 0);
      check("rst_bytes_sent", {16'b0, bytes_sent}, 0);
    end else begin
      idle = (q_tx.size() == 0) && (gap_left == 0);
      check("busy", {31'b0, busy}, {31'b0, !idle});
      check("rd_en", {31'b0, bus.rd_en}, {31'b0, idle && enable && bus.rd_valid});
      check("bytes_sent", {16'b0, bytes_sent}, m_cnt);
      if (q_tx.size() > 0) begin
        et = q_tx.pop_front();
        last = q_last.pop_front();
        check("tx", {31'b0, tx}, {31'b0, et});
        check("byte_done", {31'b0, byte_done}, {31'b0, last});
        if (last) begin
          m_cnt = (m_cnt + 1) % 65536;
          gap_left = G;
        end
      end else begin
        check("tx_idle", {31'b0, tx}, 1);
        check("byte_done_idle", {31'b0, byte_done}, 0);
        if (gap_left > 0) gap_left--;
      end
      if (idle && enable && bus.rd_valid) push_frame(bus.rd_data);
    end
  end

  task automatic wait_rd_en(output int t);
    bit found = 1'b0;
    t = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.rd_en) begin
        found = 1'b1;
        t = cyc;
        break;
      end
    end
    check("rd_en_seen", {31'b0, found}, 1);
  endtask

  task automatic wait_idle();
    bit found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy) begin
        found = 1'b1;
        break;
      end
    end
    check("idle_reached", {31'b0, found}, 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t1, t2, t3;
    rst_n = 1'b0;
    enable = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_data = 8'h00;
    repeat (3) tick();
    check("reset_tx", {31'b0, tx}, 1);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_rd_en", {31'b0, bus.rd_en}, 0);
    check("reset_bytes_sent", {16'b0, bytes_sent}, 0);
    rst_n = 1'b1;

    // single byte A5
    tick();
    enable = 1'b1;
    bus.rd_data = 8'hA5;
    bus.rd_valid = 1'b1;
    wait_rd_en(t1);
    tick();
    bus.rd_valid = 1'b0;
    wait_idle();
    check("single_bytes_sent", {16'b0, bytes_sent}, 1);

    // continuous 01 02 03
    tick();
    bus.rd_data = 8'h01;
    bus.rd_valid = 1'b1;
    wait_rd_en(t1);
    tick();
    bus.rd_data = 8'h02;
    wait_rd_en(t2);
    check("period_1_2", t2 - t1, PERIOD);
    tick();
    bus.rd_data = 8'h03;
    wait_rd_en(t3);
    check("period_2_3", t3 - t2, PERIOD);
    tick();
    bus.rd_valid = 1'b0;
    wait_idle();
    check("cont_bytes_sent", {16'b0, bytes_sent}, 4);

    // randomized handshake and data
    repeat (400) begin
      tick();
      bus.rd_data = 8'($urandom);
      bus.rd_valid = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 7) != 0);
    end
    tick();
    bus.rd_valid = 1'b0;
    enable = 1'b1;
    wait_idle();

    // enable dropped during data bit 3
    tick();
    bus.rd_data = 8'h3C;
    bus.rd_valid = 1'b1;
    wait_rd_en(t1);
    repeat (17) tick();
    enable = 1'b0;
    check("en_drop_busy", {31'b0, busy}, 1);
    wait_idle();
    repeat (60) tick();
    check("en_drop_quiet_busy", {31'b0, busy}, 0);

    // asynchronous reset in the middle of the data bits
    enable = 1'b1;
    bus.rd_data = 8'h00;
    wait_rd_en(t1);
    tick();
    bus.rd_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check("pre_reset_tx", {31'b0, tx}, 0);
    enable = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", {31'b0, tx}, 1);
    check("async_reset_busy", {31'b0, busy}, 0);
    tick();
    rst_n = 1'b1;
    enable = 1'b1;
    bus.rd_valid = 1'b1;
    wait_rd_en(t1);
    tick();
    bus.rd_valid = 1'b0;
    wait_idle();
    check("post_reset_bytes_sent", {16'b0, bytes_sent}, 1);

    // parity-relevant byte 07
    tick();
    bus.rd_data = 8'h07;
    bus.rd_valid = 1'b1;
    wait_rd_en(t1);
    tick();
    bus.rd_valid = 1'b0;
    wait_idle();
    check("final_bytes_sent", {16'b0, bytes_sent}, 2);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
